// File: rtl/hi_iso14443a_core.sv
// hi_iso14443a_core: ISO14443A HF front end - SSP framing to the ARM, ADC pause/subcarrier demodulation, reader/tag modulation.
// Define HI14A_TAGMOD2_EN to build the frame-delayed TAGSIM_MOD2 path for mode 101; otherwise 101 acts as TAGSIM_LISTEN.
module hi_iso14443a_core #(
    parameter logic [7:0] HYST_HI     = 8'd160,
    parameter logic [7:0] HYST_LO     = 8'd32,
    parameter logic [3:0] PAUSE_MIN   = 4'd2,
    parameter logic [7:0] SUBC_THRESH = 8'd24
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       ck_1356megb,
    input  logic       pck0,
    input  logic [7:0] adc_d,
    output logic       adc_clk,
    input  logic [2:0] mod_type,
    input  logic       ssp_dout,
    output logic       ssp_din,
    output logic       ssp_clk,
    output logic       ssp_frame,
    output logic       pwr_hi,
    output logic       pwr_lo,
    output logic       pwr_oe1,
    output logic       pwr_oe2,
    output logic       pwr_oe3,
    output logic       pwr_oe4,
    input  logic       cross_hi,
    input  logic       cross_lo,
    output logic       dbg
);
    localparam logic [2:0] SNIFFER       = 3'b000;
    localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;
    localparam logic [2:0] TAGSIM_MOD2   = 3'b101;

    logic [3:0] div, div_n, pcnt, pcnt_n, pk, pk_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] mn, mx, mn_n, mx_n;
    logic       fld, tx_bit, tx_n, slot_end, frame_end, is_tag, is_rdr, slot_bit, oe4_n;
    logic       unused_in;

    always_comb begin
        div_n     = div + 4'd1;
        slot_end  = div == 4'd15;
        frame_end = slot_end && bcnt == 3'd7;
        bcnt_n    = slot_end ? bcnt + 3'd1 : bcnt;
        tx_n      = div == 4'd8 ? ssp_dout : tx_bit;
        pcnt_n    = fld ? 4'd0 : (pcnt == 4'd15 ? pcnt : pcnt + 4'd1);
        pk_n      = pcnt_n > pk ? pcnt_n : pk;
        mn_n      = adc_d < mn ? adc_d : mn;
        mx_n      = adc_d > mx ? adc_d : mx;
        is_tag    = mod_type == TAGSIM_LISTEN || mod_type == TAGSIM_MOD || mod_type == TAGSIM_MOD2;
        is_rdr    = mod_type == SNIFFER || mod_type == READER_LISTEN || mod_type == READER_MOD;
        // Decision includes the current sample, so it covers all 16 clocks of the closing slot.
        slot_bit  = is_tag ? pk_n >= PAUSE_MIN : is_rdr && (mx_n - mn_n) >= SUBC_THRESH;
    end

`ifdef HI14A_TAGMOD2_EN
    logic [7:0] rxbuf, txbuf, txbuf_n;

    assign txbuf_n = frame_end ? rxbuf : txbuf;
    // Active-low replay: a 0 received in slot k modulates slot k of the following frame.
    assign oe4_n   = div_n[3] & ((mod_type == TAGSIM_MOD) ? tx_n : (mod_type == TAGSIM_MOD2) & ~txbuf_n[bcnt_n]);

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            rxbuf <= '0;
            txbuf <= '1;
        end else begin
            if (div == 4'd8) rxbuf <= {ssp_dout, rxbuf[7:1]};
            txbuf <= txbuf_n;
        end
    end
`else
    assign oe4_n = div_n[3] & (mod_type == TAGSIM_MOD) & tx_n;
`endif

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            bcnt      <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
            fld       <= 1'b1;
            tx_bit    <= 1'b0;
            pwr_oe4   <= 1'b0;
            pcnt      <= '0;
            pk        <= '0;
            mn        <= '1;
            mx        <= '0;
        end else begin
            div       <= div_n;
            bcnt      <= bcnt_n;
            ssp_clk   <= div_n[3];
            ssp_frame <= bcnt_n == 3'd0;
            tx_bit    <= tx_n;
            pwr_oe4   <= oe4_n;
            if (adc_d >= HYST_HI) fld <= 1'b1;
            else if (adc_d <= HYST_LO) fld <= 1'b0;
            if (slot_end) begin
                ssp_din <= slot_bit;
                pcnt    <= '0;
                pk      <= '0;
                mn      <= '1;
                mx      <= '0;
            end else begin
                pcnt <= pcnt_n;
                pk   <= pk_n;
                mn   <= mn_n;
                mx   <= mx_n;
            end
        end
    end

    assign pwr_hi    = ck_1356megb & ((mod_type == READER_LISTEN) | ((mod_type == READER_MOD) & ~tx_bit));
    assign pwr_lo    = 1'b0;
    assign pwr_oe1   = 1'b0;
    assign pwr_oe2   = 1'b0;
    assign pwr_oe3   = 1'b0;
    assign adc_clk   = ck_1356meg;
    assign dbg       = fld;
    assign unused_in = ^{pck0, cross_hi, cross_lo};
endmodule

// File: tb/tb_hi_iso14443a_core.sv
// tb_hi_iso14443a_core: scoreboard bench for hi_iso14443a_core; per-slot ssp_din expectations are queued and popped at slot boundaries.
module tb_hi_iso14443a_core;
`ifdef HI14A_TAGMOD2_EN
    localparam bit MOD2 = 1'b1;
`else
    localparam bit MOD2 = 1'b0;
`endif

    logic       ck = 1'b0, ckb, rst_n = 1'b0, ssp_dout = 1'b0;
    logic [7:0] adc_d = 8'd200;
    logic [2:0] mod_type = 3'b001;
    logic       adc_clk, ssp_din, ssp_clk, ssp_frame, pwr_hi, pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg;

    int         n_cmp = 0, n_bad = 0, cyc = 0, oe4_cnt = 0;
    logic       exp_q[$];
    logic       m_fld = 1'b1, m_tx = 1'b0, m_din = 1'b0;
    logic [7:0] m_rx = '0, m_txb = '1;

    hi_iso14443a_core dut (
        .ck_1356meg(ck), .rst_n(rst_n), .ck_1356megb(ckb), .pck0(1'b0), .adc_d(adc_d),
        .adc_clk(adc_clk), .mod_type(mod_type), .ssp_dout(ssp_dout), .ssp_din(ssp_din),
        .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .pwr_hi(pwr_hi), .pwr_lo(pwr_lo),
        .pwr_oe1(pwr_oe1), .pwr_oe2(pwr_oe2), .pwr_oe3(pwr_oe3), .pwr_oe4(pwr_oe4),
        .cross_hi(1'b0), .cross_lo(1'b0), .dbg(dbg)
    );

    initial forever #5 ck = ~ck;
    assign ckb = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, update the spec-level model, check after the next falling edge.
    task automatic step(input logic [7:0] a, input logic d);
        logic [3:0] dv;
        logic [2:0] bc;
        adc_d = a;
        ssp_dout = d;
        dv = cyc[3:0];
        bc = cyc[6:4];
        if (a >= 8'd160) m_fld = 1'b1;
        else if (a <= 8'd32) m_fld = 1'b0;
        if (dv == 4'd8) begin
            m_tx = d;
            m_rx = {d, m_rx[7:1]};
        end
        if (dv == 4'd15 && bc == 3'd7) m_txb = m_rx;
        @(posedge ck);
        #1 chk("pwr_hi_ck_high", pwr_hi, 0);
        @(negedge ck);
        cyc++;
        dv = cyc[3:0];
        bc = cyc[6:4];
        if (dv == 4'd0 && exp_q.size() > 0) m_din = exp_q.pop_front();
        chk("ssp_clk", ssp_clk, dv[3]);
        chk("ssp_frame", ssp_frame, bc == 3'd0);
        chk("dbg", dbg, m_fld);
        chk("ssp_din", ssp_din, m_din);
        chk("pwr_hi", pwr_hi, (mod_type == 3'd3) || (mod_type == 3'd4 && !m_tx));
        chk("pwr_oe4", pwr_oe4, (mod_type == 3'd2) ? (m_tx & dv[3]) :
                                (mod_type == 3'd5 && MOD2) ? (~m_txb[bc] & dv[3]) : 1'b0);
        chk("pwr_misc", {pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3}, 0);
        oe4_cnt += int'(pwr_oe4);
    endtask

    // One 16-clock slot: pat bit i selects lo for clock i; e is the ssp_din expected in the following slot.
    task automatic slot(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] pat, input logic d, input logic e);
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) step(pat[i] ? lo : hi, d);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_clk"}, ssp_clk, 0);
        chk({tag, "_frame"}, ssp_frame, 0);
        chk({tag, "_din"}, ssp_din, 0);
        chk({tag, "_dbg"}, dbg, 1);
        chk({tag, "_oe4"}, pwr_oe4, 0);
        chk({tag, "_hi"}, pwr_hi, 0);
    endtask

    initial begin
        repeat (3) @(negedge ck);
        check_reset("rst");
        rst_n = 1'b1;

        // TAGSIM_LISTEN: pause detection and hysteresis boundaries
        slot(8'd0, 8'd200, 16'h0000, 1'b0, 1'b0);
        slot(8'd0, 8'd200, 16'h0000, 1'b0, 1'b0);
        slot(8'd0, 8'd200, 16'h00F0, 1'b0, 1'b1);
        slot(8'd0, 8'd200, 16'h0000, 1'b0, 1'b0);
        slot(8'd0, 8'd200, 16'h0010, 1'b0, 1'b0);
        slot(8'd0, 8'd200, 16'h0030, 1'b0, 1'b1);
        slot(8'd33, 8'd200, 16'h00F0, 1'b0, 1'b0);
        slot(8'd32, 8'd200, 16'h0010, 1'b0, 1'b0);
        slot(8'd0, 8'd100, 16'h0003, 1'b0, 1'b1);
        slot(8'd100, 8'd100, 16'h0000, 1'b0, 1'b1);
        slot(8'd160, 8'd160, 16'h0000, 1'b0, 1'b0);

        // READER_LISTEN: subcarrier spread and threshold boundary
        mod_type = 3'b011;
        slot(8'd0, 8'd200, 16'hAAAA, 1'b0, 1'b1);
        slot(8'd100, 8'd100, 16'h0000, 1'b0, 1'b0);
        slot(8'd100, 8'd124, 16'h0001, 1'b0, 1'b1);
        slot(8'd100, 8'd123, 16'h0001, 1'b0, 1'b0);

        // READER_MOD: one slot of ssp_dout=1 stops the carrier
        mod_type = 3'b100;
        slot(8'd200, 8'd200, 16'h0000, 1'b1, 1'b0);
        slot(8'd200, 8'd200, 16'h0000, 1'b0, 1'b0);
        slot(8'd200, 8'd200, 16'h0000, 1'b0, 1'b0);

        mod_type = 3'b000;
        slot(8'd0, 8'd200, 16'hAAAA, 1'b0, 1'b1);
        slot(8'd200, 8'd200, 16'h0000, 1'b0, 1'b0);

        // TAGSIM_MOD: subcarrier-gated load
        mod_type = 3'b010;
        slot(8'd200, 8'd200, 16'h0000, 1'b1, 1'b0);
        slot(8'd200, 8'd200, 16'h0000, 1'b1, 1'b0);
        slot(8'd200, 8'd200, 16'h0000, 1'b0, 1'b0);
        slot(8'd200, 8'd200, 16'h0000, 1'b0, 1'b0);

        // Undefined code: no demod output, no drive
        mod_type = 3'b110;
        slot(8'd0, 8'd200, 16'hAAAA, 1'b1, 1'b0);
        slot(8'd200, 8'd200, 16'h0000, 1'b0, 1'b0);

        mod_type = 3'b001;
        while (cyc % 128 != 0) slot(8'd0, 8'd200, 16'h0000, 1'b0, 1'b0);

        // TAGSIM_MOD2: frame 0x01 replayed one frame later
        mod_type = 3'b101;
        for (int k = 0; k < 8; k++) slot(8'd0, 8'd200, 16'h0000, k == 0, 1'b0);
        oe4_cnt = 0;
        for (int k = 0; k < 8; k++) slot(8'd0, 8'd200, 16'h0000, 1'b0, 1'b0);
        chk("mod2_pulse_cycles", oe4_cnt, MOD2 ? 56 : 0);

        // Reset in the middle of a slot aborts the frame
        mod_type = 3'b001;
        slot(8'd0, 8'd200, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(8'd0, 1'b1);
        rst_n = 1'b0;
        #1 check_reset("midrst");
        repeat (2) @(negedge ck);
        check_reset("midrst_hold");
        exp_q.delete();
        cyc = 0;
        m_fld = 1'b1;
        m_tx = 1'b0;
        m_din = 1'b0;
        m_rx = '0;
        m_txb = '1;
        rst_n = 1'b1;
        slot(8'd0, 8'd200, 16'h00F0, 1'b0, 1'b1);
        slot(8'd0, 8'd200, 16'h0000, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hi_iso14443a_core.md
Name: hi_iso14443a_core

Overview:
ISO14443A high-frequency front-end block of the FPGA, clocked at 13.56 MHz. It generates the SSP serial link to the ARM (ssp_clk, ssp_frame, ssp_din, ssp_dout) and digitizes ADC samples into demodulated bits. Depending on mod_type it drives antenna power and modulation outputs for reader, tag-simulation or sniffer operation.

Parameters:
HYST_HI, 160, adc_d at or above this sets the field-present flag (fld=1)
HYST_LO, 32, adc_d at or below this clears fld (pause)
PAUSE_MIN, 2, minimum consecutive fld=0 clocks within a bit slot to report a pause
SUBC_THRESH, 24, (max-min) adc_d spread in a slot that signals load modulation

Ports:
ck_1356meg  in  1  13.56 MHz system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
ck_1356megb  in  1  inverted 13.56 MHz clock, used only to gate pwr_hi
pck0  in  1  unused
adc_d  in  8  ADC sample
adc_clk  out  1  ADC clock = ck_1356meg
mod_type  in  3  000 SNIFFER, 001 TAGSIM_LISTEN, 010 TAGSIM_MOD, 011 READER_LISTEN, 100 READER_MOD, 101 TAGSIM_MOD2
ssp_dout  in  1  serial data from ARM
ssp_din  out  1  serial data to ARM
ssp_clk  out  1  SSP bit clock, 847.5 kHz
ssp_frame  out  1  byte-frame marker
pwr_hi  out  1  reader carrier drive
pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3  out  1 each  tied 0
pwr_oe4  out  1  tag load modulation
cross_hi, cross_lo  in  1 each  unused
dbg  out  1  copy of fld

Behaviour:
- div: 4-bit free-running counter; bcnt: 3-bit counter, increments when div wraps 15->0.
- ssp_clk is registered = div[3]: low for div 0..7, high for div 8..15. One bit slot = 16 clocks. One frame = 8 slots = 128 clocks.
- ssp_frame is registered, high while bcnt==0, i.e. 16 of every 128 clocks.
- ssp_din updates only at the div 15->0 transition (ssp_clk falling edge). It is stable across the rising edge.
- ssp_dout is sampled when div==8 (ssp_clk rising edge) into tx_bit.
- fld hysteresis: fld<=1 if adc_d>=HYST_HI; fld<=0 if adc_d<=HYST_LO; otherwise hold.
- Per slot:
  - pcnt counts consecutive fld=0 clocks and saturates at 15.
  - mn/mx track the min and max of adc_d.
  - All three reset at the slot start.
- ssp_din at each slot boundary, reflecting the previous slot:
  - TAGSIM_LISTEN, TAGSIM_MOD, TAGSIM_MOD2: 1 if peak pcnt>=PAUSE_MIN, else 0.
  - SNIFFER, READER_LISTEN, READER_MOD: 1 if (mx-mn)>=SUBC_THRESH, else 0. The subtraction is unsigned 8-bit and mx>=mn always.
  - Undefined codes 110 and 111: ssp_din=0, all pwr_* outputs 0.
- pwr_hi:
  - READER_LISTEN: ck_1356megb.
  - READER_MOD: ck_1356megb & ~tx_bit, so tx_bit=1 stops the carrier.
  - All other modes: 0.
- pwr_oe4:
  - TAGSIM_MOD: tx_bit & div[3], i.e. a subcarrier-gated load for the second half of the slot.
  - TAGSIM_MOD2: txb & div[3], with txb as defined below.
  - All other modes: 0.
- TAGSIM_MOD2 data path:
  - The 8 tx_bit samples of a frame are shifted into rxbuf.
  - At the frame boundary (bcnt 7->0, div 15->0), rxbuf is copied to txbuf.
  - During the next frame, slot k emits txb = ~txbuf bit k, with bit 0 being the first received. Data is active-low, so ssp_dout=0 means modulate.
  - Latency is exactly one frame (128 clocks).
- mod_type changes take effect next clock. Counters are not reset, so framing stays continuous.
- Reset values:
  - div=0, bcnt=0.
  - ssp_clk=0, ssp_frame=0, ssp_din=0.
  - fld=1, tx_bit=0, rxbuf=0, txbuf=0xFF (no modulation).
  - pwr_oe4=0. pwr_hi follows its combinational definition with tx_bit=0.
- Reset asserted mid-frame aborts the frame. After release, framing restarts at slot 0.

Optional Feature:
HI14A_TAGMOD2_EN: when defined, mode 101 behaves as TAGSIM_MOD2 above. When undefined, rxbuf/txbuf are not built and mode 101 behaves exactly as TAGSIM_LISTEN, with pwr_oe4=0.

Test Plan:
- Reset then release -> ssp_clk period 16 clocks, ssp_frame high 16 of 128 clocks, first frame rises 1 clock after release. All pwr_* = 0 in TAGSIM_LISTEN.
- TAGSIM_LISTEN, adc_d=200 steady, then 0 for 4 clocks within one slot -> ssp_din=1 for exactly the following slot, 0 otherwise. dbg low for the same 4 clocks (+1 latency).
- READER_LISTEN, adc_d alternating 0/200 each clock -> ssp_din=1 every slot. Constant adc_d=100 -> ssp_din=0.
- READER_MOD, ssp_dout=1 for one slot -> pwr_hi=0 from the sampling point (div 8) until the next sample. With ssp_dout=0, pwr_hi tracks ck_1356megb.
- TAGSIM_MOD, ssp_dout=1 -> pwr_oe4 high for div 8..15 of the following slots. ssp_dout=0 -> pwr_oe4=0.
- TAGSIM_MOD2 (macro on), frame data 0x01 on ssp_dout -> next frame pwr_oe4 pulses in slots 1..7 only. Macro off -> pwr_oe4 stays 0.
